lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Multi-cycle load/store sequencer between the core's execute stage and a word-addressed data memory port.
- Accepts one RV32I load/store at a time and drives the memory request handshake.
- Generates byte strobes for stores.
- Selects and sign- or zero-extends load data, the memory-side counterpart of the immediate sign extender.
- Returns a single result/error response to writeback.

Parameters:
DATA_WIDTH, 32, data and address width; only 32 is supported.
TIMEOUT_CYCLES, 255, number of WAIT cycles before a timeout error; used only with LSU_TIMEOUT_EN.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  controller can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  DATA_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
req_rd  in  5  destination register tag, returned unchanged
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts the request
mem_addr  out  DATA_WIDTH  word address: {req_addr[31:2], 2'b00}
mem_we  out  1  write enable
mem_wstrb  out  4  byte strobes
mem_wdata  out  DATA_WIDTH  lane-replicated store data
mem_rsp_valid  in  1  read data valid; single-cycle pulse, no backpressure
mem_rdata  in  DATA_WIDTH  read word
rsp_valid  out  1  result valid
rsp_ready  in  1  writeback accepts the result
rsp_data  out  DATA_WIDTH  extended load data; 0 for stores and errors
rsp_rd  out  5  tag of the completed operation
rsp_err  out  1  misaligned access, illegal funct3, or timeout

Behaviour:
- States IDLE, REQ, WAIT, RESP.
- Reset value of all outputs is 0, except req_ready = 1. State resets to IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we, funct3, addr, wdata and rd.
  - If the request is legal, go to REQ. Otherwise set the error flag and go to RESP; memory is never touched.
- Illegal requests:
  - Load funct3 in {011, 110, 111}.
  - Store funct3 >= 011.
  - Halfword with addr[0] = 1.
  - Word with addr[1:0] != 0.
- REQ:
  - mem_req_valid = 1; all mem_* outputs stay stable until mem_req_ready.
  - On handshake, a store goes to RESP and a load goes to WAIT.
- Store strobes and data:
  - SB: wstrb = 0001 << addr[1:0], wdata = {4{byte}}.
  - SH: wstrb = 0011 << addr[1:0], wdata = {2{half}}.
  - SW: wstrb = 1111.
- WAIT:
  - On mem_rsp_valid, select the byte or half lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Register the result into rsp_data, then go to RESP.
- RESP:
  - rsp_valid = 1 with data, rd and err held stable until rsp_ready.
  - On the rsp_ready handshake, go to IDLE.
  - No new request is accepted in the same cycle; the next accept is one cycle later.
- Latency from the accept cycle t, with zero-wait memory:
  - Store: rsp_valid at t+2.
  - Load with response at t+2: rsp_valid at t+3.
  - Error: rsp_valid at t+1.
- mem_rsp_valid outside WAIT is ignored, including stale responses after a reset.
- Asserting rst_n low mid-operation immediately drops mem_req_valid and rsp_valid and returns to IDLE; the in-flight operation is discarded.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined: an 8+ bit counter clears on WAIT entry and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES with no mem_rsp_valid, go to RESP with rsp_err = 1 and rsp_data = 0. A late response is ignored.
- Undefined: WAIT holds indefinitely; no counter logic is instantiated.

Decomposition:
- Package isa_shared: funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW) and enum lsu_state_t {LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_RESP}.
- Sub-module load_align: combinational lane select plus sign/zero extension. Inputs: rdata, addr[1:0], funct3. Output: 32-bit data.

Test Plan:
- LB at addr 0x103, mem_rdata 0x80FF_0000 -> rsp_data 0xFFFF_FF80, rsp_err 0, rsp_rd echoed, rsp_valid at t+3.
- LHU at addr 0x202, mem_rdata 0xBEEF_1234 -> rsp_data 0x0000_BEEF.
- SH at addr 0x006, wdata 0x0000_ABCD, mem_req_ready stalled 3 cycles -> mem_addr 0x4, wstrb 1100, wdata 0xABCD_ABCD held stable throughout; rsp_valid 1 cycle after the handshake, rsp_data 0.
- LW at addr 0x001 -> no mem_req_valid, rsp_err 1 at t+1. SW with funct3 011 -> rsp_err 1.
- rsp_ready held low 5 cycles -> rsp_* stable, req_ready 0. Reset asserted in WAIT, then a stale mem_rsp_valid -> outputs at reset values, no rsp_valid.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4, load with no response -> rsp_err 1 after 4 WAIT cycles; a later mem_rsp_valid is ignored.

Source files
------------

// File: rtl/isa_shared.sv
// Shared RV32I load/store definitions for the LSU slice.
// Contents: funct3 encodings, LSU FSM state enum, memory request payload,
// and the legality check for a load/store request.
package isa_shared;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_t;

  // Memory-side request payload, held stable while mem_req_valid is high.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            we;
    logic [3:0]      wstrb;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

  // 1 when funct3 is a valid encoding for the direction and the address is naturally aligned.
  function automatic logic lsu_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    if (we) begin
      case (f3)
        F3_SB:   ok = 1'b1;
        F3_SH:   ok = ~a[0];
        F3_SW:   ok = (a == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: ok = 1'b1;
        F3_LH, F3_LHU: ok = ~a[0];
        F3_LW:         ok = (a == 2'b00);
        default:       ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core/memory/writeback bus bundle for lsu_ctrl.
// slave  : view taken by lsu_ctrl (drives req_ready, mem_req_*, mem_addr/we/wstrb/wdata, rsp_*).
// master : view taken by the surrounding core/memory (drives the opposite direction).
interface lsu_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [4:0]            req_rd;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [3:0]            mem_wstrb;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [4:0]            rsp_rd;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    input  rsp_ready,
    output req_ready,
    output mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    output rsp_valid, rsp_data, rsp_rd, rsp_err
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    output rsp_ready,
    input  req_ready,
    input  mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    input  rsp_valid, rsp_data, rsp_rd, rsp_err
  );

endinterface

// File: rtl/load_align.sv
// Combinational load-data lane select with sign/zero extension.
// Ports: rdata_i (read word), addr_i (byte offset), funct3_i (load type),
//        data_o (extended result; 0 for non-load encodings).
module load_align
  import isa_shared::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o   = '0;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data_o = rdata_i;
      F3_LBU:  data_o = {24'h000000, byte_sel};
      F3_LHU:  data_o = {16'h0000, half_sel};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle RV32I load/store sequencer: one operation at a time from the
// execute stage to a word-addressed memory port, one response to writeback.
// Ports: clk, rst_n (async active-low), bus (lsu_ctrl_if.slave: request,
//        memory request/response, writeback response).
// Optional LSU_TIMEOUT_EN: WAIT gives up after TIMEOUT_CYCLES cycles with rsp_err.
module lsu_ctrl
  import isa_shared::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input logic       clk,
  input logic       rst_n,
  lsu_ctrl_if.slave bus
);

  // Only a 32-bit datapath exists; a zero timeout would never leave WAIT sensibly.
  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("lsu_ctrl: DATA_WIDTH must be 32 and TIMEOUT_CYCLES nonzero");
  end

  lsu_state_t            state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic                  rsp_valid_q, rsp_valid_d;
  mem_req_t              mem_q, mem_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            lane_q, lane_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [4:0]            rd_q, rd_d;
  logic                  err_q, err_d;

  logic [XLEN-1:0]       align_data;
  logic [3:0]            st_strb;
  logic [XLEN-1:0]       st_wdata;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] cnt_q, cnt_d;
`endif

  load_align u_load_align (
    .rdata_i  (bus.mem_rdata),
    .addr_i   (lane_q),
    .funct3_i (f3_q),
    .data_o   (align_data)
  );

  // Store strobes and lane-replicated data from the incoming request.
  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = bus.req_wdata;
    case (bus.req_funct3)
      F3_SB: begin
        st_strb  = 4'b0001 << bus.req_addr[1:0];
        st_wdata = {4{bus.req_wdata[7:0]}};
      end
      F3_SH: begin
        st_strb  = 4'b0011 << bus.req_addr[1:0];
        st_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = bus.req_wdata;
      end
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    we_d       = we_q;
    f3_d       = f3_q;
    lane_d     = lane_q;
    rsp_data_d = rsp_data_q;
    rd_d       = rd_q;
    err_d      = err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    unique case (state_q)
      LSU_IDLE: begin
        if (bus.req_valid) begin
          we_d       = bus.req_we;
          f3_d       = bus.req_funct3;
          lane_d     = bus.req_addr[1:0];
          rd_d       = bus.req_rd;
          rsp_data_d = '0;
          if (lsu_legal(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
            err_d       = 1'b0;
            mem_d.addr  = {bus.req_addr[31:2], 2'b00};
            mem_d.we    = bus.req_we;
            mem_d.wstrb = bus.req_we ? st_strb : 4'b0000;
            mem_d.wdata = bus.req_we ? st_wdata : '0;
            state_d     = LSU_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = LSU_RESP;
          end
        end
      end
      LSU_REQ: begin
        if (bus.mem_req_ready) begin
          state_d = we_q ? LSU_RESP : LSU_WAIT;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      LSU_WAIT: begin
        if (bus.mem_rsp_valid) begin
          rsp_data_d = align_data;
          state_d    = LSU_RESP;
        end
`ifdef LSU_TIMEOUT_EN
        // This is the TIMEOUT_CYCLES-th WAIT cycle without a response.
        else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d      = 1'b1;
          rsp_data_d = '0;
          state_d    = LSU_RESP;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
`endif
      end
      LSU_RESP: begin
        if (bus.rsp_ready) begin
          state_d = LSU_IDLE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase

    // Handshake outputs are a registered decode of the next state.
    req_ready_d     = (state_d == LSU_IDLE);
    mem_req_valid_d = (state_d == LSU_REQ);
    rsp_valid_d     = (state_d == LSU_RESP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= LSU_IDLE;
      req_ready_q     <= 1'b1;
      mem_req_valid_q <= 1'b0;
      rsp_valid_q     <= 1'b0;
      mem_q           <= '0;
      we_q            <= 1'b0;
      f3_q            <= 3'b000;
      lane_q          <= 2'b00;
      rsp_data_q      <= '0;
      rd_q            <= 5'd0;
      err_q           <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      rsp_valid_q     <= rsp_valid_d;
      mem_q           <= mem_d;
      we_q            <= we_d;
      f3_q            <= f3_d;
      lane_q          <= lane_d;
      rsp_data_q      <= rsp_data_d;
      rd_q            <= rd_d;
      err_q           <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q           <= cnt_d;
`endif
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_addr      = mem_q.addr;
  assign bus.mem_we        = mem_q.we;
  assign bus.mem_wstrb     = mem_q.wstrb;
  assign bus.mem_wdata     = mem_q.wdata;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_rd        = rd_q;
  assign bus.rsp_err       = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed requests push expected writeback
// responses; a negedge monitor pops and compares on every rsp handshake.
module tb_lsu_ctrl;
  import isa_shared::*;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t exp_q[$];

  lsu_ctrl_if #(.DATA_WIDTH(32)) bus ();

  lsu_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: a response handshake completes at the next posedge.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: got data 0x%08h rd %0d err %0b with nothing expected",
                 bus.rsp_data, bus.rsp_rd, bus.rsp_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_data", bus.rsp_data, e.data);
        check("rsp_rd", 32'(bus.rsp_rd), 32'(e.rd));
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic [4:0] rd, input logic err);
    exp_t e;
    e.data = d;
    e.rd   = rd;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
    tick();
    bus.req_valid  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.req_ready && n < 64) begin
      tick();
      n++;
    end
    check("wait_idle_bound", 32'(n < 64), 32'd1);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [4:0] rd, input logic [31:0] exp_d, input int hold);
    expect_rsp(exp_d, rd, 1'b0);
    bus.mem_req_ready = 1'b1;
    bus.rsp_ready     = (hold == 0);
    issue(1'b0, f3, addr, 32'h0, rd);
    check("ld_mreq_valid", 32'(bus.mem_req_valid), 32'd1);
    check("ld_maddr", bus.mem_addr, {addr[31:2], 2'b00});
    check("ld_mwe", 32'(bus.mem_we), 32'd0);
    tick();
    check("ld_early_rsp", 32'(bus.rsp_valid), 32'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = rdata;
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h0;
    check("ld_lat_t3", 32'(bus.rsp_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_data", bus.rsp_data, exp_d);
      check("hold_rd", 32'(bus.rsp_rd), 32'(rd));
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    wait_idle();
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input int stall, input logic [31:0] e_addr,
                          input logic [3:0] e_strb, input logic [31:0] e_wdata);
    expect_rsp(32'h0, rd, 1'b0);
    bus.rsp_ready     = 1'b1;
    bus.mem_req_ready = (stall == 0);
    issue(1'b1, f3, addr, wd, rd);
    for (int i = 0; i <= stall; i++) begin
      if (i == stall) bus.mem_req_ready = 1'b1;
      check("st_mreq_valid", 32'(bus.mem_req_valid), 32'd1);
      check("st_maddr", bus.mem_addr, e_addr);
      check("st_mwe", 32'(bus.mem_we), 32'd1);
      check("st_wstrb", 32'(bus.mem_wstrb), 32'(e_strb));
      check("st_wdata", bus.mem_wdata, e_wdata);
      tick();
    end
    check("st_rsp_after_hs", 32'(bus.rsp_valid), 32'd1);
    check("st_mreq_dropped", 32'(bus.mem_req_valid), 32'd0);
    wait_idle();
  endtask

  task automatic do_err(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [4:0] rd);
    expect_rsp(32'h0, rd, 1'b1);
    bus.rsp_ready     = 1'b1;
    bus.mem_req_ready = 1'b1;
    issue(we, f3, addr, 32'hFFFF_FFFF, rd);
    check("err_lat_t1", 32'(bus.rsp_valid), 32'd1);
    check("err_no_mem", 32'(bus.mem_req_valid), 32'd0);
    wait_idle();
    check("err_no_mem_after", 32'(bus.mem_req_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp             = 0;
    n_err             = 0;
    rst_n             = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_we        = 1'b0;
    bus.req_funct3    = 3'b000;
    bus.req_addr      = 32'h0;
    bus.req_wdata     = 32'h0;
    bus.req_rd        = 5'd0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h0;
    bus.rsp_ready     = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mreq_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
    rst_n = 1'b1;
    tick();

    do_load(F3_LB,  32'h0000_0103, 32'h80FF_0000, 5'd7,  32'hFFFF_FF80, 0);
    do_load(F3_LHU, 32'h0000_0202, 32'hBEEF_1234, 5'd9,  32'h0000_BEEF, 0);
    do_load(F3_LH,  32'h0000_0100, 32'h1234_8001, 5'd10, 32'hFFFF_8001, 0);
    do_load(F3_LBU, 32'h0000_0101, 32'h0000_9A00, 5'd11, 32'h0000_009A, 0);
    do_load(F3_LW,  32'h0000_0010, 32'hDEAD_BEEF, 5'd12, 32'hDEAD_BEEF, 5);

    do_store(F3_SH, 32'h0000_0006, 32'h0000_ABCD, 5'd13, 3, 32'h0000_0004, 4'b1100, 32'hABCD_ABCD);
    do_store(F3_SB, 32'h0000_0013, 32'hAAAA_AA55, 5'd14, 0, 32'h0000_0010, 4'b1000, 32'h5555_5555);
    do_store(F3_SW, 32'h0000_0020, 32'h1234_5678, 5'd15, 1, 32'h0000_0020, 4'b1111, 32'h1234_5678);

    do_err(1'b0, F3_LW,  32'h0000_0001, 5'd16);
    do_err(1'b1, 3'b011, 32'h0000_0000, 5'd17);
    do_err(1'b0, 3'b110, 32'h0000_0000, 5'd18);
    do_err(1'b0, F3_LH,  32'h0000_0003, 5'd19);

    // Reset while a load waits in WAIT, then a stale memory response.
    bus.mem_req_ready = 1'b1;
    issue(1'b0, F3_LW, 32'h0000_0040, 32'h0, 5'd20);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_mreq_valid", 32'(bus.mem_req_valid), 32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'hCAFE_F00D;
    tick();
    bus.mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stale_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("stale_req_ready", 32'(bus.req_ready), 32'd1);
      check("stale_rsp_data", bus.rsp_data, 32'h0);
      tick();
    end

    do_load(F3_LB, 32'h0000_0042, 32'h0011_2233, 5'd21, 32'h0000_0011, 0);

`ifdef LSU_TIMEOUT_EN
    // Load with no memory response: error after TO WAIT cycles, late data ignored.
    expect_rsp(32'h0, 5'd22, 1'b1);
    bus.mem_req_ready = 1'b1;
    bus.rsp_ready     = 1'b1;
    issue(1'b0, F3_LW, 32'h0000_0080, 32'h0, 5'd22);
    tick();
    for (int i = 0; i < int'(TO); i++) begin
      check("to_wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    check("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("to_rsp_err", 32'(bus.rsp_err), 32'd1);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h1357_9BDF;
    tick();
    bus.mem_rsp_valid = 1'b0;
    check("to_late_ignored", 32'(bus.rsp_valid), 32'd0);
    check("to_back_idle", 32'(bus.req_ready), 32'd1);
`endif

    for (int i = 0; i < 16 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
